// File: rtl/serial_frame_pkg.sv
// Shared state encoding and line-level constants for the serial frame transmitter.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } tx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_BIT  = 1'b0;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero; zero_o flags an exhausted count.
module down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, MSB-first payload, stop bit, idle gap.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between payload and stop.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_value,
  output logic              out_active,
  output logic              busy
);

  localparam int unsigned BitW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GapW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              bit_zero, gap_zero;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  // Parity is captured with the word, since the shift register is consumed by the payload.
  logic parity_q, parity_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  down_counter #(
    .Width (BitW)
  ) u_bit_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (state_q == START),
    .en_i       (state_q == DATA),
    .load_val_i (BitW'(DATA_W - 1)),
    .zero_o     (bit_zero)
  );

  down_counter #(
    .Width (GapW)
  ) u_gap_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (state_q == STOP),
    .en_i       (state_q == GAP),
    .load_val_i (GapW'(GapLoad)),
    .zero_o     (gap_zero)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    out_value  = IDLE_BIT;
    out_active = 1'b0;
    busy       = 1'b1;
    in_ready   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = reset;
        if (in_valid && reset) begin
          state_d = START;
          shift_d = in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          parity_d = ^in_data;
`endif
        end
      end
      START: begin
        out_value  = START_BIT;
        out_active = 1'b1;
        state_d    = DATA;
      end
      DATA: begin
        out_value  = shift_q[DATA_W-1];
        out_active = 1'b1;
        shift_d    = shift_q << 1;
        if (bit_zero) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        out_value  = parity_q;
        out_active = 1'b1;
        state_d    = STOP;
      end
`endif
      STOP: begin
        out_value  = STOP_BIT;
        out_active = 1'b1;
        state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized scoreboard bench for serial_frame_tx: expected line bits are queued at each
// accepted word and popped by an independent monitor every cycle the transmitter is busy.
module tb_serial_frame_tx;

  localparam int DW  = 8;
  localparam int GAP = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_LEN = 1 + 1 + DW + PAR + 1 + GAP;

  typedef struct packed {
    logic val;
    logic act;
  } exp_bit_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_value, out_active, busy;

  exp_bit_t exp_q[$];
  int       n_cmp = 0;
  int       n_err = 0;
  bit       mon_en = 1'b0;

  serial_frame_tx #(
    .DATA_W     (DW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_value  (out_value),
    .out_active (out_active),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start, payload MSB first, optional even parity, stop, then idle gap.
  function automatic void push_frame(input logic [DW-1:0] w);
    exp_q.push_back('{val: 1'b1, act: 1'b1});
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back('{val: w[i], act: 1'b1});
    if (PAR != 0) exp_q.push_back('{val: ^w, act: 1'b1});
    exp_q.push_back('{val: 1'b0, act: 1'b1});
    for (int i = 0; i < GAP; i++) exp_q.push_back('{val: 1'b0, act: 1'b0});
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      exp_bit_t e;
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("busy_without_frame", 32'(busy), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_value", 32'(out_value), 32'(e.val));
          check("out_active", 32'(out_active), 32'(e.act));
        end
      end else begin
        check("idle_out_value", 32'(out_value), 32'd0);
        check("idle_out_active", 32'(out_active), 32'd0);
        check("frame_cut_short", 32'(exp_q.size()), 32'd0);
      end
      check("in_ready_rule", 32'(in_ready), 32'((!busy) && reset));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [DW-1:0] w, output time t_acc);
    in_valid = 1'b1;
    in_data  = w;
    t_acc    = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk);
        push_frame(w);
        t_acc = $time;
        @(negedge clk);
        // Scribble on in_data while busy; it must be ignored.
        in_data = DW'($urandom);
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = DW'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      @(negedge clk);
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    time t1, t2;
    #1 reset = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out_value", 32'(out_value), 32'd0);
    @(negedge clk);

    // Directed single frame, then back-to-back with in_valid held high.
    send(8'hA5, t1);
    drain();
    send(8'h07, t1);
    drain();
    send(8'hFF, t1);
    send(8'h00, t2);
    check("b2b_period", 32'((t2 - t1) / 10), 32'(FRAME_LEN));
    drain();

    // Randomized traffic with random idle spacing.
    for (int k = 0; k < 30; k++) begin
      send(DW'($urandom), t1);
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(0, 5));
    end
    drain();

    // Abort mid-frame during the 4th payload bit.
    send(8'hFF, t1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_out_value", 32'(out_value), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h3C, t1);
    drain();

    // Stall with toggling data.
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'($urandom);
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd1);
      check("stall_out_value", 32'(out_value), 32'd0);
    end

    send(8'h81, t1);
    drain();
    @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
